// File: rtl/keypad_scanner_if.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner_if
//  Description : Keypad matrix and key-event signal bundle for keypad_scanner.
//                master = scanner side, slave = keypad/consumer side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface keypad_scanner_if;
    logic [3:0] row_n;      // keypad rows, active-low, asynchronous
    logic [3:0] col_n;      // column drive, active-low one-hot
    logic [7:0] key_code;   // last accepted key code
    logic       key_valid;  // one-cycle strobe per accepted press
    logic       key_down;   // accepted key still held

    modport master (
        input  row_n,
        output col_n,
        output key_code,
        output key_valid,
        output key_down
    );

    modport slave (
        output row_n,
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_down
    );
endinterface
`default_nettype wire

// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scanner
//  Description : 4x4 matrix keypad scanner with press/release debounce and
//                key-code encoding for the game control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_CYCLES = 20000
) (
    input  wire logic         clk,
    input  wire logic         rst,
    keypad_scanner_if.master  kif
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEB_CYCLES);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    col_q, col_d;
    logic [1:0]    row_q, row_d;        // candidate row
    logic [DW-1:0] dwell_q, dwell_d;
    logic [CW-1:0] cnt_q, cnt_d;        // debounce / release counter
    logic [7:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          down_q, down_d;
    logic [3:0]    rs_meta_q, rs_q;

    logic          one_low;
    logic [1:0]    low_row;
    logic [3:0]    cand_pat;

    // Segment code for key index = col*4 + row
    function automatic logic [7:0] key_lut(input logic [3:0] idx);
        case (idx)
            4'd0:  key_lut = 8'hB0;
            4'd1:  key_lut = 8'hA4;
            4'd2:  key_lut = 8'hF9;
            4'd3:  key_lut = 8'hC0;
            4'd4:  key_lut = 8'hF8;
            4'd5:  key_lut = 8'h82;
            4'd6:  key_lut = 8'h92;
            4'd7:  key_lut = 8'h99;
            4'd8:  key_lut = 8'h83;
            4'd9:  key_lut = 8'h88;
            4'd10: key_lut = 8'h90;
            4'd11: key_lut = 8'h80;
            4'd12: key_lut = 8'h8E;
            4'd13: key_lut = 8'h86;
            4'd14: key_lut = 8'hA1;
            4'd15: key_lut = 8'hC6;
        endcase
    endfunction

    assign kif.col_n     = ~(4'b0001 << col_q);
    assign kif.key_code  = code_q;
    assign kif.key_valid = valid_q;
    assign kif.key_down  = down_q;

    assign cand_pat = ~(4'b0001 << row_q);

    // Recognise a row pattern with exactly one row pulled low
    always_comb begin
        one_low = 1'b1;
        low_row = 2'd0;
        case (rs_q)
            4'b1110: low_row = 2'd0;
            4'b1101: low_row = 2'd1;
            4'b1011: low_row = 2'd2;
            4'b0111: low_row = 2'd3;
            default: one_low = 1'b0;
        endcase
    end

    // Two-flop synchronizer on the asynchronous row inputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs_meta_q <= 4'hF;
            rs_q      <= 4'hF;
        end else begin
            rs_meta_q <= kif.row_n;
            rs_q      <= rs_meta_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SCAN;
            col_q   <= 2'd0;
            row_q   <= 2'd0;
            dwell_q <= '0;
            cnt_q   <= '0;
            code_q  <= 8'h00;
            valid_q <= 1'b0;
            down_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            dwell_q <= dwell_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            down_q  <= down_d;
        end
    end

    // Scan / debounce / hold next-state and output logic
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        dwell_d = dwell_q;
        cnt_d   = cnt_q;
        code_d  = code_q;
        valid_d = 1'b0;
        down_d  = down_q;

        case (state_q)
            SCAN: begin
                if (dwell_q == DWELL_LAST) begin
                    if (one_low) begin
                        // Keep the column driven while the candidate settles
                        row_d   = low_row;
                        cnt_d   = '0;
                        state_d = DEBOUNCE;
                    end else begin
                        col_d   = col_q + 2'd1;
                        dwell_d = '0;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (rs_q == cand_pat) begin
                    if (cnt_q == DEB_LAST) begin
                        code_d  = key_lut({col_q, row_q});
                        valid_d = 1'b1;
                        down_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = HELD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                    state_d = SCAN;
                end
            end

            HELD: begin
                // Any low row restarts the release count, so other keys on
                // this column also hold off the release
                if (rs_q == 4'hF) begin
                    if (cnt_q == DEB_LAST) begin
                        down_d  = 1'b0;
                        col_d   = col_q + 2'd1;
                        dwell_d = '0;
                        cnt_d   = '0;
                        state_d = SCAN;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = '0;
                end
            end

            default: state_d = SCAN;
        endcase
    end

endmodule
`default_nettype wire
